// File: rtl/imm_gen_pkg.sv
// rtl/imm_gen_pkg.sv - shared opcodes and format codes for the immediate generator
//
// Purpose: RISC-V base opcodes recognised by the decoder, the format code
//          enumeration returned on fmt_o, and the format used for opcodes
//          that match no listed entry.
// Macro:   IMM_GEN_ILLEGAL_EN - unlisted opcodes map to FMT_ILL instead of FMT_I.

package imm_gen_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_t;

`ifdef IMM_GEN_ILLEGAL_EN
  localparam fmt_t FMT_UNLISTED = FMT_ILL;
`else
  localparam fmt_t FMT_UNLISTED = FMT_I;
`endif

endpackage

// File: rtl/imm_gen_decode.sv
// rtl/imm_gen_decode.sv - combinational instruction to immediate/format decoder
//
// Purpose: classify a 32-bit instruction by opcode and build its immediate,
//          sign-extended from instr_i[31] to XLEN bits.
// Ports:   instr_i   in  32    instruction word
//          imm_o     out XLEN  sign-extended immediate (0 for R and ILL)
//          fmt_o     out 3     format code
//          illegal_o out 1     opcode unrecognised (only with IMM_GEN_ILLEGAL_EN)
// Macro:   IMM_GEN_ILLEGAL_EN - adds illegal_o and the FMT_ILL classification.

module imm_gen_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
`ifdef IMM_GEN_ILLEGAL_EN
  output logic            illegal_o,
`endif
  output logic [XLEN-1:0] imm_o,
  output fmt_t            fmt_o
);

  localparam bit RV64 = (XLEN == 64);

  logic signed [31:0] w_imm32;

  // The *32 opcodes only exist on RV64; on RV32 they fall through as unlisted.
  always_comb begin
    fmt_o = FMT_UNLISTED;
    case (instr_i[6:0])
      OP_LOAD, OP_IMM, OP_JALR: fmt_o = FMT_I;
      OP_IMM32:                 if (RV64) fmt_o = FMT_I;
      OP_STORE:                 fmt_o = FMT_S;
      OP_BRANCH:                fmt_o = FMT_B;
      OP_LUI, OP_AUIPC:         fmt_o = FMT_U;
      OP_JAL:                   fmt_o = FMT_J;
      OP_REG:                   fmt_o = FMT_R;
      OP_REG32:                 if (RV64) fmt_o = FMT_R;
      default:                  ;
    endcase
  end

  // Every layout already carries instr_i[31] at bit 31, so one signed
  // widening below covers all formats, including U on RV64.
  always_comb begin
    w_imm32 = '0;
    case (fmt_o)
      FMT_I: w_imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      FMT_S: w_imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      FMT_B: w_imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                        instr_i[30:25], instr_i[11:8], 1'b0};
      FMT_U: w_imm32 = {instr_i[31:12], 12'b0};
      FMT_J: w_imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                        instr_i[20], instr_i[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  assign imm_o = XLEN'(w_imm32);

`ifdef IMM_GEN_ILLEGAL_EN
  assign illegal_o = (fmt_o == FMT_ILL);
`endif

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined immediate generator with in-order result FIFO
//
// Purpose: decode accepted instructions and queue {imm, fmt, illegal, tag}
//          in a DEPTH-entry FIFO; outputs come from FIFO storage only.
// Ports:   clk_i, rst_i (sync, active-high)
//          valid_i/ready_o, instr_i[31:0], tag_i[TAG_W-1:0]   input side
//          valid_o/ready_i, imm_o[XLEN-1:0], fmt_o[2:0],
//          tag_o[TAG_W-1:0], illegal_o                        output side
// Macro:   IMM_GEN_ILLEGAL_EN - stores and returns the illegal flag;
//          otherwise illegal_o is tied to 0.

module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,   // power of two, 2..8
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [31:0]      instr_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [XLEN-1:0]  imm_o,
  output logic [2:0]       fmt_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             illegal_o
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [XLEN-1:0]  r_imm_mem [DEPTH];
  logic [2:0]       r_fmt_mem [DEPTH];
  logic [TAG_W-1:0] r_tag_mem [DEPTH];

  logic             w_push;
  logic             w_pop;
  logic [XLEN-1:0]  w_dec_imm;
  fmt_t             w_dec_fmt;

`ifdef IMM_GEN_ILLEGAL_EN
  logic [DEPTH-1:0] r_ill_mem;
  logic             w_dec_ill;
`endif

  imm_gen_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .instr_i   (instr_i),
`ifdef IMM_GEN_ILLEGAL_EN
    .illegal_o (w_dec_ill),
`endif
    .imm_o     (w_dec_imm),
    .fmt_o     (w_dec_fmt)
  );

  // ready_o is held low for the whole reset window; full is judged on the
  // pre-edge count, so a same-cycle pop never frees a slot for a push.
  assign ready_o = !rst_i && (r_count != FULL_CNT);
  assign valid_o = (r_count != '0);
  assign w_push  = valid_i && ready_o;
  assign w_pop   = valid_o && ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      // Storage is cleared so the head reads as all-zero right after reset.
      for (int k = 0; k < DEPTH; k++) begin
        r_imm_mem[k] <= '0;
        r_fmt_mem[k] <= '0;
        r_tag_mem[k] <= '0;
      end
`ifdef IMM_GEN_ILLEGAL_EN
      r_ill_mem <= '0;
`endif
    end else begin
      if (w_push) begin
        r_imm_mem[r_wr_ptr] <= w_dec_imm;
        r_fmt_mem[r_wr_ptr] <= w_dec_fmt;
        r_tag_mem[r_wr_ptr] <= tag_i;
`ifdef IMM_GEN_ILLEGAL_EN
        r_ill_mem[r_wr_ptr] <= w_dec_ill;
`endif
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign imm_o = r_imm_mem[r_rd_ptr];
  assign fmt_o = r_fmt_mem[r_rd_ptr];
  assign tag_o = r_tag_mem[r_rd_ptr];

`ifdef IMM_GEN_ILLEGAL_EN
  assign illegal_o = r_ill_mem[r_rd_ptr];
`else
  assign illegal_o = 1'b0;
`endif

endmodule
